hazard_forward_unit: RTL

// Parametrised hazard/forwarding scoreboard for the pipelined MIPS core; successor to the fixed 5-stage per-stage "can forward" flags.

---
 rtl/hazard_forward_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// ============================================================================
// Module   : hazard_forward_unit
// Summary  : Hazard/forwarding scoreboard. Tracks in-flight producers through
//            DEPTH post-decode stages, drives the D stall, the D/E forward
//            selects and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_forward_unit #(
    parameter int DEPTH = 4,
    parameter int NRD   = 2,
    parameter int RA_W  = 5,
    parameter int TW    = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d_valid,
    input  logic [NRD*RA_W-1:0]  d_src,
    input  logic [NRD*TW-1:0]    d_tuse,
    input  logic                 d_we,
    input  logic [RA_W-1:0]      d_dst,
    input  logic [TW-1:0]        d_tnew,
    input  logic                 flush,
    output logic                 stall,
    output logic [NRD*4-1:0]     d_fwd_sel,
    output logic [NRD*4-1:0]     e_fwd_sel,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [TW-1:0] c_tnew_one = TW'(1);

    // Entry k holds the producer that is k stages past decode (1 = E).
    logic                r_v    [1:DEPTH];
    logic [RA_W-1:0]     r_dst  [1:DEPTH];
    logic [TW-1:0]       r_tnew [1:DEPTH];
    logic [NRD*RA_W-1:0] r_e_src;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_stall_req;
    logic                w_advance;
    logic                w_hit;
    logic [3:0]          w_k;
    logic [TW-1:0]       w_tn;
    logic [RA_W-1:0]     w_src;

    assign stall     = d_valid & w_stall_req;
    assign w_advance = ~stall & ~flush;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_v[k]    <= 1'b0;
                r_dst[k]  <= '0;
                r_tnew[k] <= '0;
            end
            r_e_src     <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_v[1]    <= d_valid & d_we & (d_dst != '0) & w_advance;
            r_dst[1]  <= d_dst;
            r_tnew[1] <= d_tnew;
            for (int k = 2; k <= DEPTH; k++) begin
                r_v[k]    <= r_v[k-1];
                r_dst[k]  <= r_dst[k-1];
                r_tnew[k] <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - c_tnew_one;
            end
            r_e_src <= w_advance ? d_src : '0;
            if (stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Scans run oldest-to-youngest so the youngest match is the one kept.
    always_comb begin
        w_stall_req = 1'b0;
        d_fwd_sel   = '0;
        e_fwd_sel   = '0;
        w_hit       = 1'b0;
        w_k         = '0;
        w_tn        = '0;
        w_src       = '0;
        for (int i = 0; i < NRD; i++) begin
            w_src = d_src[i*RA_W +: RA_W];
            w_hit = 1'b0;
            w_k   = '0;
            w_tn  = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_v[k] && (r_dst[k] == w_src) && (w_src != '0)) begin
                    w_hit = 1'b1;
                    w_k   = 4'(k);
                    w_tn  = r_tnew[k];
                end
            end
            if (w_hit && (w_tn > d_tuse[i*TW +: TW]))
                w_stall_req = 1'b1;
            if (w_hit && (w_tn == '0))
                d_fwd_sel[i*4 +: 4] = w_k;

            w_src = r_e_src[i*RA_W +: RA_W];
            w_hit = 1'b0;
            w_k   = '0;
            w_tn  = '0;
            for (int k = DEPTH; k >= 2; k--) begin
                if (r_v[k] && (r_dst[k] == w_src) && (w_src != '0)) begin
                    w_hit = 1'b1;
                    w_k   = 4'(k);
                    w_tn  = r_tnew[k];
                end
            end
            if (w_hit && (w_tn == '0))
                e_fwd_sel[i*4 +: 4] = w_k;
        end
    end

endmodule

`default_nettype wire
